// File: rtl/encoder_scheduler_if.sv
// Request/response channels between the bus front-end (master) and encoder_scheduler (slave).
interface encoder_scheduler_if #(
  parameter int unsigned AMBA_WORD = 32
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [AMBA_WORD-1:0] req0_data;
  logic [1:0]           req0_width;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [AMBA_WORD-1:0] req1_data;
  logic [1:0]           req1_width;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [AMBA_WORD-1:0] rsp_data;
  logic                 rsp_err;

  modport master (
    output req0_valid, req0_data, req0_width,
    input  req0_ready,
    output req1_valid, req1_data, req1_width,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_width,
    output req0_ready,
    input  req1_valid, req1_data, req1_width,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/encoder_scheduler.sv
// Shares one encoder between two requesters: arbitrate, align, strobe, capture, respond.
// Optional ENC_SCHED_RR_EN selects round-robin tie-breaking; default is fixed priority to req0.
module encoder_scheduler #(
  parameter int unsigned AMBA_WORD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  encoder_scheduler_if.slave   bus,
  output logic [AMBA_WORD-1:0] enc_data,
  output logic                 enc_small,
  output logic                 enc_medium,
  output logic                 enc_large,
  output logic [1:0]           enc_width,
  input  logic [AMBA_WORD-1:0] enc_out,
  output logic                 busy,
  output logic [15:0]          ops_cnt
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SH_SML  = 28;
  localparam int unsigned SH_MED  = 21;
  localparam int unsigned SH_LRG  = 6;
  localparam logic [1:0]  W_SML   = 2'b00;
  localparam logic [1:0]  W_MED   = 2'b01;
  localparam logic [1:0]  W_LRG   = 2'b10;
  localparam logic [1:0]  W_BAD   = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t               state;
  logic                 tie_grant;
  logic                 grant;
  logic                 accept;
  logic [AMBA_WORD-1:0] sel_data;
  logic [1:0]           sel_width;
  logic [AMBA_WORD-1:0] aligned;

`ifdef ENC_SCHED_RR_EN
  logic last_served;

  // Both valid: the requester not served last wins.
  always_comb tie_grant = ~last_served;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_served <= 1'b1;
    end else if (accept) begin
      last_served <= grant;
    end
  end
`else
  always_comb tie_grant = 1'b0;
`endif

  // Grant, ready and left-alignment of the selected requester's info bits.
  always_comb begin
    grant     = 1'b0;
    sel_data  = bus.req0_data;
    sel_width = bus.req0_width;
    aligned   = '0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = tie_grant;
    end else begin
      grant = ~bus.req0_valid;
    end
    accept         = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = accept && !grant;
    bus.req1_ready = accept && grant;
    if (grant) begin
      sel_data  = bus.req1_data;
      sel_width = bus.req1_width;
    end
    // Shifting the full word drops info bits beyond the selected width.
    case (sel_width)
      W_SML:   aligned = sel_data << SH_SML;
      W_MED:   aligned = sel_data << SH_MED;
      W_LRG:   aligned = sel_data << SH_LRG;
      default: aligned = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      ops_cnt       <= '0;
      enc_data      <= '0;
      enc_small     <= 1'b0;
      enc_medium    <= 1'b0;
      enc_large     <= 1'b0;
      enc_width     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            busy       <= 1'b1;
            bus.rsp_id <= grant;
            if (sel_width == W_BAD) begin
              // Invalid width bypasses the encoder and leaves its inputs untouched.
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.rsp_err <= 1'b0;
              enc_data    <= aligned;
              enc_width   <= sel_width;
              enc_small   <= (sel_width == W_SML);
              enc_medium  <= (sel_width == W_MED);
              enc_large   <= (sel_width == W_LRG);
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          bus.rsp_data  <= enc_out;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            ops_cnt       <= ops_cnt + CNT_W'(1);
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_scheduler.sv
// Scoreboard bench for encoder_scheduler with a stand-in registered encoder.
module tb_encoder_scheduler;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  encoder_scheduler_if #(.AMBA_WORD(W)) bus();
  logic [W-1:0] enc_data;
  logic [W-1:0] enc_out = '0;
  logic         enc_small, enc_medium, enc_large;
  logic [1:0]   enc_width;
  logic         busy;
  logic [15:0]  ops_cnt;

  encoder_scheduler #(.AMBA_WORD(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .enc_data(enc_data), .enc_small(enc_small), .enc_medium(enc_medium),
    .enc_large(enc_large), .enc_width(enc_width), .enc_out(enc_out),
    .busy(busy), .ops_cnt(ops_cnt)
  );

  // Stand-in encoder: info bits followed by an even-parity bit, registered.
  always @(posedge clk) begin
    if (enc_small)       enc_out <= {24'd0, enc_data[31:28], 3'd0, ^enc_data[31:28]};
    else if (enc_medium) enc_out <= {20'd0, enc_data[31:21], ^enc_data[31:21]};
    else if (enc_large)  enc_out <= {5'd0, enc_data[31:6], ^enc_data[31:6]};
    else                 enc_out <= '0;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: codeword the requester should get back for its raw request.
  function automatic logic [31:0] exp_code(input logic [31:0] d, input logic [1:0] w);
    case (w)
      2'd0:    return {24'd0, d[3:0], 3'd0, ^d[3:0]};
      2'd1:    return {20'd0, d[10:0], ^d[10:0]};
      2'd2:    return {5'd0, d[25:0], ^d[25:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_align(input logic [31:0] d, input logic [1:0] w);
    case (w)
      2'd0:    return {d[3:0], 28'd0};
      2'd1:    return {d[10:0], 21'd0};
      2'd2:    return {d[25:0], 6'd0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit pred_grant(input bit v0, input bit v1, input bit p);
    if (v0 && v1) begin
`ifdef ENC_SCHED_RR_EN
      return ~p;
`else
      return 1'b0;
`endif
    end
    return !v0;
  endfunction

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  bit          outst     = 0;
  bit          ptr       = 1;
  logic [15:0] exp_ops   = '0;
  int          acc_cyc   = 0;
  int          exp_lat   = 0;
  bit          rsp_seen  = 0;
  bit          issue_chk = 0;
  logic [31:0] last_enc  = '0;
  logic [4:0]  last_strb = '0;

  // Monitor: predicts readys, logs accepts into the scoreboard, checks responses.
  always @(negedge clk) begin
    bit          g, p0, p1;
    logic [31:0] d;
    logic [1:0]  w;
    exp_t        e;
    if (!rst) begin
      q.delete();
      outst = 0; ptr = 1; exp_ops = '0; rsp_seen = 0; issue_chk = 0;
      last_enc = '0; last_strb = '0;
    end else begin
      if (issue_chk && cyc == acc_cyc) begin
        chk("enc_data", enc_data, last_enc);
        chk("enc_strobes", {27'd0, enc_small, enc_medium, enc_large, enc_width}, {27'd0, last_strb});
        issue_chk = 0;
      end
      g  = pred_grant(bus.req0_valid, bus.req1_valid, ptr);
      p0 = !outst && bus.req0_valid && !g;
      p1 = !outst && bus.req1_valid && g;
      chk("ready", {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, p1, p0});
      if (!outst && (bus.req0_valid || bus.req1_valid)) begin
        d = g ? bus.req1_data : bus.req0_data;
        w = g ? bus.req1_width : bus.req0_width;
        e.id = g; e.err = (w == 2'd3); e.data = exp_code(d, w);
        q.push_back(e);
        outst = 1; acc_cyc = cyc + 1; exp_lat = e.err ? 0 : 2; issue_chk = 1;
        if (!e.err) begin
          last_enc  = exp_align(d, w);
          last_strb = {w == 2'd0, w == 2'd1, w == 2'd2, w};
        end
        ptr = g;
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end else begin
          chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, q[0].id});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, q[0].err});
          chk("rsp_data", bus.rsp_data, q[0].data);
          if (!rsp_seen) begin
            chk("rsp_latency", cyc - acc_cyc, exp_lat);
            rsp_seen = 1;
          end
          if (bus.rsp_ready) begin
            chk("ops_cnt", {16'd0, ops_cnt}, {16'd0, exp_ops});
            exp_ops = exp_ops + 16'd1;
            void'(q.pop_front());
            outst = 0; rsp_seen = 0;
          end
        end
      end
    end
  end

  task automatic send(input bit id, input logic [31:0] d, input logic [1:0] w);
    bit got = 0;
    @(posedge clk); #1;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_width = w; end
    else    begin bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_width = w; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) got = 1;
    end
    chk("send_accept", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1;
    end
    chk("rsp_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (!busy && !bus.rsp_valid) got = 1;
    end
    chk("idle_timeout", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] save_enc;
    logic [15:0] bp_ops;
    bit          g;
    bit          tie_exp [4];
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_width = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_width = '0;
    bus.rsp_ready  = 1'b0;
`ifdef ENC_SCHED_RR_EN
    tie_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    tie_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_ops_cnt", {16'd0, ops_cnt}, 32'd0);
    chk("rst_enc_data", enc_data, 32'd0);
    chk("rst_enc_strb", {27'd0, enc_small, enc_medium, enc_large, enc_width}, 32'd0);
    chk("rst_rsp", {bus.rsp_data[29:0], bus.rsp_id, bus.rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;

    // Small encode.
    send(1'b0, 32'h0000_000B, 2'b00);
    @(negedge clk);
    chk("small_enc_data", enc_data, 32'hB000_0000);
    chk("small_strobes", {29'd0, enc_small, enc_medium, enc_large}, 32'd4);
    chk("small_width", {30'd0, enc_width}, 32'd0);
    wait_rsp();
    chk("small_rsp_data", bus.rsp_data, 32'h0000_00B1);
    chk("small_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    wait_idle();

    // Invalid width.
    save_enc = enc_data;
    send(1'b1, 32'hFFFF_FFFF, 2'b11);
    @(negedge clk);
    chk("err_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("err_rsp_fields", {bus.rsp_data[29:0], bus.rsp_id, bus.rsp_err}, 32'd3);
    chk("err_enc_hold", enc_data, save_enc);
    chk("err_strb_hold", {29'd0, enc_small, enc_medium, enc_large}, 32'd4);
    wait_idle();

    // Tie, both requesters valid continuously.
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit got = 0;
      bus.req0_data = $urandom; bus.req0_width = 2'($urandom_range(0, 2));
      bus.req1_data = $urandom; bus.req1_width = 2'($urandom_range(0, 2));
      g = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (bus.req0_ready || bus.req1_ready) begin got = 1; g = bus.req1_ready; end
      end
      chk("tie_accept", {31'd0, got}, 32'd1);
      chk($sformatf("tie_grant%0d", k), {31'd0, g}, {31'd0, tie_exp[k]});
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle();

    // Backpressure in RESP.
    bus.rsp_ready = 1'b0;
    send(1'b0, $urandom, 2'b01);
    wait_rsp();
    bp_ops = exp_ops;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_readys", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      chk("bp_ops_cnt", {16'd0, ops_cnt}, {16'd0, bp_ops});
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_release_ops", {16'd0, ops_cnt}, {16'd0, bp_ops + 16'd1});

    // Reset during CAPTURE.
    send(1'b0, $urandom, 2'b10);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_ops", {16'd0, ops_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end

    // Randomized traffic with random backpressure.
    repeat (1500) begin
      @(posedge clk); #1;
      bus.req0_valid = ($urandom_range(0, 9) < 6);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      bus.req0_data  = $urandom; bus.req0_width = 2'($urandom_range(0, 3));
      bus.req1_data  = $urandom; bus.req1_width = 2'($urandom_range(0, 3));
      bus.rsp_ready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle();

    // Counter wrap.
    @(posedge clk); #2;
    force dut.ops_cnt = 16'hFFFF;
    exp_ops = 16'hFFFF;
    #1;
    release dut.ops_cnt;
    send(1'b1, $urandom, 2'b00);
    wait_idle();
    @(negedge clk);
    chk("wrap_ops_cnt", {16'd0, ops_cnt}, 32'd0);
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
